ifid_hazard_stage: RTL and testbench

IF/ID pipeline register for the five-stage MIPS core, merged with load-use hazard detection and branch/jump flush control. It sits between the instruction fetch logic (PC and Instruction_Memory) and the ID stage. It drives the PC write enable and the ID/EX control-bubble select. It also keeps saturating cycle, stall and flush counters that the testbench reads hierarchically each cycle.

---
 rtl/mips_pkg.sv | 21 ++
 rtl/ifid_hazard_stage_if.sv | 36 +++
 rtl/load_use_detect.sv | 26 ++
 rtl/ifid_hazard_stage.sv | 92 +++++++++
 tb/tb_ifid_hazard_stage.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Opcode constants and field-usage helpers for the five-stage MIPS core.
package mips_pkg;

    localparam logic [5:0]  OP_RTYPE = 6'h00;
    localparam logic [5:0]  OP_BEQ   = 6'h04;
    localparam logic [5:0]  OP_J     = 6'h02;
    localparam logic [5:0]  OP_LW    = 6'h23;
    localparam logic [5:0]  OP_SW    = 6'h2B;
    localparam logic [31:0] NOP_WORD = 32'h0;

    // Only j lacks an rs source; lw/addi etc. read rs as the base/operand.
    function automatic logic uses_rs(input logic [5:0] op);
        return op != OP_J;
    endfunction

    // rt is a source only for R-type, beq and sw; for lw/addi it is a destination.
    function automatic logic uses_rt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/ifid_hazard_stage_if.sv
// Fetch/ID-EX side signals of the IF/ID hazard stage, bundled with master/slave views.
interface ifid_hazard_stage_if #(
    parameter int PC_W  = 32,
    parameter int CNT_W = 32
);
    logic             start_i;
    logic [PC_W-1:0]  if_pc_i;
    logic [31:0]      if_instr_i;
    logic             idex_memread_i;
    logic [4:0]       idex_rt_i;
    logic             branch_taken_i;
    logic             jump_i;
    logic [PC_W-1:0]  ifid_pc_o;
    logic [31:0]      ifid_instr_o;
    logic             ifid_valid_o;
    logic             pc_write_o;
    logic             bubble_o;
    logic             flush_o;
    logic [CNT_W-1:0] cycle_cnt_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;

    modport master (
        output start_i, if_pc_i, if_instr_i, idex_memread_i, idex_rt_i,
               branch_taken_i, jump_i,
        input  ifid_pc_o, ifid_instr_o, ifid_valid_o, pc_write_o, bubble_o,
               flush_o, cycle_cnt_o, stall_cnt_o, flush_cnt_o
    );

    modport slave (
        input  start_i, if_pc_i, if_instr_i, idex_memread_i, idex_rt_i,
               branch_taken_i, jump_i,
        output ifid_pc_o, ifid_instr_o, ifid_valid_o, pc_write_o, bubble_o,
               flush_o, cycle_cnt_o, stall_cnt_o, flush_cnt_o
    );
endinterface

// File: rtl/load_use_detect.sv
// Raw load-use hazard: the lw in EX writes a register the IF/ID instruction reads.
module load_use_detect
    import mips_pkg::*;
(
    input  logic [15:0] instr_hi_i,   // IF/ID instruction bits [31:16]
    input  logic        idex_memread_i,
    input  logic [4:0]  idex_rt_i,
    output logic        stall_raw_o
);
    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       rs_hit;
    logic       rt_hit;

    assign op = instr_hi_i[15:10];
    assign rs = instr_hi_i[9:5];
    assign rt = instr_hi_i[4:0];

    assign rs_hit = uses_rs(op) && (rs == idex_rt_i);
    assign rt_hit = uses_rt(op) && (rt == idex_rt_i);

    // $zero is never a real dependency, so a nop can never stall.
    assign stall_raw_o = idex_memread_i && (idex_rt_i != 5'd0) && (rs_hit || rt_hit);

endmodule

// File: rtl/ifid_hazard_stage.sv
// IF/ID pipeline register with load-use stall, branch/jump flush and event counters.
module ifid_hazard_stage
    import mips_pkg::*;
#(
    parameter int PC_W  = 32,
    parameter int CNT_W = 32
) (
    input  logic clk_i,
    input  logic rst_i,
    ifid_hazard_stage_if.slave bus
);
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [31:0]      instr_q, instr_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic stall_raw;
    logic stall;
    logic flush;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != {CNT_W{1'b1}})) ? v + 1'b1 : v;
    endfunction

    load_use_detect u_load_use_detect (
        .instr_hi_i     (instr_q[31:16]),
        .idex_memread_i (bus.idex_memread_i),
        .idex_rt_i      (bus.idex_rt_i),
        .stall_raw_o    (stall_raw)
    );

    // Reset masks the hazard terms so no bubble/flush leaks out while rst_i is high.
    assign stall = valid_q && bus.start_i && stall_raw && !rst_i;
    assign flush = valid_q && bus.start_i && (bus.branch_taken_i || bus.jump_i) && !stall && !rst_i;

    assign bus.pc_write_o = bus.start_i && !stall && !rst_i;
    assign bus.bubble_o   = stall;
    assign bus.flush_o    = flush;

    always_comb begin
        pc_d        = pc_q;
        instr_d     = instr_q;
        valid_d     = valid_q;
        cycle_cnt_d = cycle_cnt_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (bus.start_i) begin
            cycle_cnt_d = sat_inc(cycle_cnt_q, 1'b1);
            stall_cnt_d = sat_inc(stall_cnt_q, stall);
            flush_cnt_d = sat_inc(flush_cnt_q, flush);
            if (stall) begin
                pc_d    = pc_q;
            end else if (flush) begin
                pc_d    = '0;
                instr_d = NOP_WORD;
                valid_d = 1'b0;
            end else begin
                pc_d    = bus.if_pc_i;
                instr_d = bus.if_instr_i;
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q        <= '0;
            instr_q     <= '0;
            valid_q     <= 1'b0;
            cycle_cnt_q <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            valid_q     <= valid_d;
            cycle_cnt_q <= cycle_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.ifid_pc_o    = pc_q;
    assign bus.ifid_instr_o = instr_q;
    assign bus.ifid_valid_o = valid_q;
    assign bus.cycle_cnt_o  = cycle_cnt_q;
    assign bus.stall_cnt_o  = stall_cnt_q;
    assign bus.flush_cnt_o  = flush_cnt_q;

endmodule

// File: tb/tb_ifid_hazard_stage.sv
// Directed bench for ifid_hazard_stage; a second 4-bit-counter instance checks saturation.
module tb_ifid_hazard_stage;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_s = 1'b1;
    int   compared = 0;
    int   mismatched = 0;

    always #5 clk = ~clk;

    ifid_hazard_stage_if #(.PC_W(32), .CNT_W(32)) bus ();
    ifid_hazard_stage_if #(.PC_W(32), .CNT_W(4))  sbus ();

    ifid_hazard_stage #(.PC_W(32), .CNT_W(32)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    ifid_hazard_stage #(.PC_W(32), .CNT_W(4)) dut_sat (
        .clk_i (clk),
        .rst_i (rst_s),
        .bus   (sbus.slave)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
            $error("check %s", tag);
        end
        $display("check %-14s obs=%h exp=%h", tag, obs, exp);
    endtask

    task automatic check_regs(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                              input logic valid);
        check({tag, ".pc"}, bus.ifid_pc_o, pc);
        check({tag, ".instr"}, bus.ifid_instr_o, instr);
        check({tag, ".valid"}, {31'd0, bus.ifid_valid_o}, {31'd0, valid});
    endtask

    task automatic check_ctl(input string tag, input logic pcw, input logic bub, input logic fl);
        check({tag, ".pcw"}, {31'd0, bus.pc_write_o}, {31'd0, pcw});
        check({tag, ".bubble"}, {31'd0, bus.bubble_o}, {31'd0, bub});
        check({tag, ".flush"}, {31'd0, bus.flush_o}, {31'd0, fl});
    endtask

    task automatic check_cnt(input string tag, input int cyc, input int stl, input int fl);
        check({tag, ".cyc"}, bus.cycle_cnt_o, cyc);
        check({tag, ".stall"}, bus.stall_cnt_o, stl);
        check({tag, ".flcnt"}, bus.flush_cnt_o, fl);
    endtask

    initial begin
        bus.start_i = 0; bus.if_pc_i = 0; bus.if_instr_i = 0;
        bus.idex_memread_i = 0; bus.idex_rt_i = 0;
        bus.branch_taken_i = 0; bus.jump_i = 0;
        sbus.start_i = 0; sbus.if_pc_i = 0; sbus.if_instr_i = 0;
        sbus.idex_memread_i = 0; sbus.idex_rt_i = 0;
        sbus.branch_taken_i = 0; sbus.jump_i = 0;

        // Reset for two edges
        step(); step();
        check_regs("rst", 0, 0, 0);
        check_ctl("rst", 0, 0, 0);
        check_cnt("rst", 0, 0, 0);

        // addi at pc 4
        rst = 0; bus.start_i = 1; bus.if_pc_i = 4; bus.if_instr_i = 32'h2008_0005;
        #1 check_ctl("empty", 1, 0, 0);
        step();
        check_regs("addi", 4, 32'h2008_0005, 1);
        check_cnt("addi", 1, 0, 0);

        // add $t1,$t0,$t0 then load-use on $t0
        bus.if_pc_i = 8; bus.if_instr_i = 32'h0108_4820;
        step();
        bus.idex_memread_i = 1; bus.idex_rt_i = 8;
        bus.if_pc_i = 12; bus.if_instr_i = 32'h012A_5820;
        #1 check_ctl("lu", 0, 1, 0);
        step();
        check_regs("lu_hold", 8, 32'h0108_4820, 1);
        check_cnt("lu_hold", 3, 1, 0);
        bus.idex_memread_i = 0;
        #1 check_ctl("lu_rel", 1, 0, 0);
        step();
        check_regs("lu_next", 12, 32'h012A_5820, 1);

        // idex_rt = 0 never stalls
        bus.if_pc_i = 16; bus.if_instr_i = 32'h0108_4820;
        step();
        bus.idex_memread_i = 1; bus.idex_rt_i = 0;
        bus.if_pc_i = 20; bus.if_instr_i = 32'h8D48_0000;
        #1 check_ctl("rt0", 1, 0, 0);
        step();
        // lw $t0,0($t2): rt is a destination, rs=10 is a source
        bus.idex_rt_i = 8;
        #1 check_ctl("lw_rt", 1, 0, 0);
        bus.idex_rt_i = 10;
        #1 check_ctl("lw_rs", 0, 1, 0);

        // beq taken, no hazard
        bus.idex_memread_i = 0; bus.idex_rt_i = 0;
        bus.if_pc_i = 24; bus.if_instr_i = 32'h1109_0003;
        step();
        bus.branch_taken_i = 1; bus.if_pc_i = 28; bus.if_instr_i = 32'h2210_0001;
        #1 check_ctl("beq", 1, 0, 1);
        step();
        check_regs("beq_fl", 0, 0, 0);
        check_cnt("beq_fl", 8, 1, 1);
        check_ctl("fl_empty", 1, 0, 0);

        // Fetched nop loads as valid and cannot stall
        bus.branch_taken_i = 0; bus.if_pc_i = 32; bus.if_instr_i = 32'h0;
        step();
        check_regs("nop", 32, 0, 1);
        bus.idex_memread_i = 1; bus.idex_rt_i = 8;
        #1 check_ctl("nop", 1, 0, 0);

        // Stall together with a taken branch: stall first, flush next cycle
        bus.idex_memread_i = 0; bus.if_pc_i = 36; bus.if_instr_i = 32'h1109_0003;
        step();
        bus.idex_memread_i = 1; bus.idex_rt_i = 8; bus.branch_taken_i = 1;
        #1 check_ctl("st_br", 0, 1, 0);
        step();
        check_regs("st_br", 36, 32'h1109_0003, 1);
        check_cnt("st_br", 11, 2, 1);
        bus.idex_memread_i = 0;
        #1 check_ctl("br_after", 1, 0, 1);
        step();
        check_cnt("br_after", 12, 2, 2);
        check("br_after.v", {31'd0, bus.ifid_valid_o}, 32'd0);

        // j whose rs field matches idex_rt: no stall, flush
        bus.branch_taken_i = 0; bus.if_pc_i = 40; bus.if_instr_i = 32'h0900_0010;
        step();
        bus.idex_memread_i = 1; bus.idex_rt_i = 8; bus.jump_i = 1;
        #1 check_ctl("jmp", 1, 0, 1);
        step();
        check_cnt("jmp", 14, 2, 3);

        // Freeze with start low while a hazard is present
        bus.jump_i = 0; bus.idex_memread_i = 0; bus.if_pc_i = 44; bus.if_instr_i = 32'h0108_4820;
        step();
        bus.start_i = 0; bus.idex_memread_i = 1; bus.idex_rt_i = 8;
        bus.if_pc_i = 48; bus.if_instr_i = 32'h0000_0000;
        #1 check_ctl("frz", 0, 0, 0);
        step(); step(); step();
        check_regs("frz", 44, 32'h0108_4820, 1);
        check_cnt("frz", 15, 2, 3);
        bus.start_i = 1;
        #1 check_ctl("resume", 0, 1, 0);
        step();
        check_cnt("resume", 16, 3, 3);
        check_regs("resume", 44, 32'h0108_4820, 1);

        // Reset during a stall
        rst = 1;
        #1 check_ctl("rst_st", 0, 0, 0);
        step();
        check_regs("rst_st", 0, 0, 0);
        check_cnt("rst_st", 0, 0, 0);
        rst = 0; bus.idex_memread_i = 0;

        // Saturation on a 4-bit counter instance
        rst_s = 0; sbus.start_i = 1;
        for (int i = 0; i < 15; i++) step();
        check("sat_at_max", {28'd0, sbus.cycle_cnt_o}, 32'd15);
        step(); step();
        check("sat_hold", {28'd0, sbus.cycle_cnt_o}, 32'd15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
